// File: rtl/ballot_unit_if.sv
// ballot_unit_if: officer/button inputs and vote outputs of the ballot capture stage.
//   arm          officer enable (rising edge arms one ballot)
//   btn_raw[2:0] asynchronous party buttons (bit0 = party1 .. bit2 = party3)
//   voter_switch one-hot vote, non-zero only while voting_en is high
//   voting_en    single-cycle vote strobe
//   ready_led    high while a ballot is armed
//   reject       single-cycle pulse on a refused multi-button press
//   timeout      single-cycle pulse when an armed ballot expires
//   ballots_cast saturating count of accepted votes
// master = the side driving arm/btn_raw; slave = ballot_unit.
interface ballot_unit_if;
    logic       arm;
    logic [2:0] btn_raw;
    logic [2:0] voter_switch;
    logic       voting_en;
    logic       ready_led;
    logic       reject;
    logic       timeout;
    logic [7:0] ballots_cast;

    modport master (
        output arm, btn_raw,
        input  voter_switch, voting_en, ready_led, reject, timeout, ballots_cast
    );

    modport slave (
        input  arm, btn_raw,
        output voter_switch, voting_en, ready_led, reject, timeout, ballots_cast
    );
endinterface

// File: rtl/ballot_unit.sv
// ballot_unit: synchronises and debounces three party buttons and accepts one
// vote per officer arm press, emitting a one-hot voter_switch strobe qualified
// by voting_en for the downstream tally counter.
// Ports:
//   clk  sole clock, rising edge
//   rst  synchronous active-high reset
//   bus  ballot_unit_if.slave (arm, btn_raw in; vote/status outputs, all registered)
// Parameters:
//   DEBOUNCE_CYCLES  debounce length and settle window (>= 1)
//   TIMEOUT_CYCLES   armed idle limit, used only with BALLOT_TIMEOUT_EN
// Optional feature: define BALLOT_TIMEOUT_EN to expire ballots that sit armed
// for TIMEOUT_CYCLES; otherwise timeout is held at 0.
module ballot_unit #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 65535
) (
    input  logic          clk,
    input  logic          rst,
    ballot_unit_if.slave  bus
);

    localparam int unsigned NB   = 3;
    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED_CLR,
        S_ARMED,
        S_SETTLE,
        S_CAST
    } state_e;

    logic [NB-1:0]   sync1_q, sync2_q, btn_db_q;
    logic [DB_W-1:0] db_cnt_q [NB];
    logic            arm_q, arm_rise_q;

    state_e          state_q, state_d;
    logic [DB_W-1:0] settle_q, settle_d;
    logic [NB-1:0]   vote_d;
    logic            reject_d, timeout_d;
    logic            onehot_c;

    logic [NB-1:0]   voter_switch_q;
    logic            voting_en_q, ready_led_q, reject_q, timeout_q;
    logic [7:0]      ballots_q;

    // Two-flop synchroniser followed by a per-bit disagreement-count debouncer
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            btn_db_q <= '0;
            for (int i = 0; i < NB; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q <= bus.btn_raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < NB; i++) begin
                if (sync2_q[i] == btn_db_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    // this edge is the D-th consecutive disagreement
                    btn_db_q[i] <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // Arm rising edge, registered so the FSM reacts one edge after arm is first seen
    always_ff @(posedge clk) begin
        if (rst) begin
            arm_q      <= 1'b0;
            arm_rise_q <= 1'b0;
        end else begin
            arm_q      <= bus.arm;
            arm_rise_q <= bus.arm & ~arm_q;
        end
    end

    assign onehot_c = (btn_db_q != 3'b000) && ((btn_db_q & (btn_db_q - 3'd1)) == 3'b000);

`ifdef BALLOT_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`else
    localparam int unsigned timeout_cfg_unused = TIMEOUT_CYCLES;
`endif

    // Ballot FSM next-state and output decode
    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        vote_d    = '0;
        reject_d  = 1'b0;
        timeout_d = 1'b0;
`ifdef BALLOT_TIMEOUT_EN
        tmo_d     = tmo_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (arm_rise_q) state_d = S_ARMED_CLR;
            end
            S_ARMED_CLR: begin
                // a button held through arming must be released first
                if (btn_db_q == 3'b000) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (btn_db_q != 3'b000) begin
                    settle_d = DB_W'(DEBOUNCE_CYCLES);
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                settle_d = settle_q - DB_W'(1);
                // counter reaches 0 on this edge: sample the debounced buttons
                if (settle_q <= DB_W'(1)) begin
                    settle_d = '0;
                    if (onehot_c) begin
                        vote_d  = btn_db_q;
                        state_d = S_CAST;
                    end else begin
                        reject_d = 1'b1;
                        state_d  = S_ARMED_CLR;
                    end
                end
            end
            S_CAST: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
`ifdef BALLOT_TIMEOUT_EN
        // idle limit spans ARMED_CLR and ARMED; SETTLE is exempt
        if (state_q == S_ARMED_CLR || state_q == S_ARMED) begin
            if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                timeout_d = 1'b1;
                state_d   = S_IDLE;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
        if (state_d == S_ARMED_CLR && state_q != S_ARMED_CLR) tmo_d = '0;
`endif
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            settle_q       <= '0;
            voter_switch_q <= '0;
            voting_en_q    <= 1'b0;
            ready_led_q    <= 1'b0;
            reject_q       <= 1'b0;
            timeout_q      <= 1'b0;
            ballots_q      <= '0;
        end else begin
            state_q        <= state_d;
            settle_q       <= settle_d;
            voter_switch_q <= vote_d;
            voting_en_q    <= (state_d == S_CAST);
            ready_led_q    <= (state_d == S_ARMED_CLR) || (state_d == S_ARMED) ||
                              (state_d == S_SETTLE);
            reject_q       <= reject_d;
            timeout_q      <= timeout_d;
            if (state_d == S_CAST && ballots_q != 8'hFF) ballots_q <= ballots_q + 8'd1;
        end
    end

`ifdef BALLOT_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) tmo_q <= '0;
        else     tmo_q <= tmo_d;
    end
`endif

    assign bus.voter_switch = voter_switch_q;
    assign bus.voting_en    = voting_en_q;
    assign bus.ready_led    = ready_led_q;
    assign bus.reject       = reject_q;
    assign bus.timeout      = timeout_q;
    assign bus.ballots_cast = ballots_q;

endmodule

// File: doc/ballot_unit.md
# ballot_unit

Front-end ballot capture stage that sits directly upstream of the vote tally counter and drives its `voter_switch` and `voting_en` inputs. Synchronises and debounces three raw party push-buttons and accepts exactly one vote per officer `arm` press. A valid choice becomes a single-cycle, one-hot `voter_switch` strobe qualified by `voting_en`. Multi-button presses are rejected before they reach the tally.

## Interface
- `DEBOUNCE_CYCLES`, 16: cycles a synchronised button must disagree with its debounced state before that state flips. Also sets the length of the settle window. Must be ≥1.
- `TIMEOUT_CYCLES`, 65535: armed-state idle limit. Used only when `BALLOT_TIMEOUT_EN` is defined.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset. Synchronous, active-high.
- `arm`  in  1  officer enable, already clean. Only its rising edge is used.
- `btn_raw`  in  3  asynchronous party buttons. Bit0 = party1, bit1 = party2, bit2 = party3.
- `voter_switch`  out  3  one-hot vote, valid only while `voting_en` = 1. Otherwise 3'b000.
- `voting_en`  out  1  one-cycle vote strobe.
- `ready_led`  out  1  high while a ballot is armed (ARMED_CLR, ARMED, SETTLE).
- `reject`  out  1  one-cycle pulse when a multi-button press is refused.
- `timeout`  out  1  one-cycle pulse when an armed ballot expires.
- `ballots_cast`  out  8  count of accepted votes, saturating.

## Operation
- **Synchroniser:** each `btn_raw` bit passes through a 2-flop synchroniser.
- **Debouncer:** one per bit, with a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - The counter increments while the synchronised bit ≠ `btn_db`, and clears whenever they agree.
  - On reaching `DEBOUNCE_CYCLES`, `btn_db` takes the synchronised value and the counter clears.
- **Arm edge detect:** `arm_q` register. `arm_rise` = `arm & ~arm_q`.
- **FSM states:**
  - IDLE: `arm_rise` → ARMED_CLR.
  - ARMED_CLR: waits for `btn_db` == 0 → ARMED. Prevents a button held through arming from voting.
  - ARMED: on `btn_db` ≠ 0, load the settle counter with `DEBOUNCE_CYCLES` → SETTLE.
  - SETTLE: decrement the counter each cycle. At 0, sample `btn_db`:
    - exactly one bit set → latch it → CAST;
    - otherwise (two or more bits set, or all released) → pulse `reject` → ARMED_CLR. The ballot stays armed.
  - CAST: one cycle only. `voting_en` = 1 and `voter_switch` = latched one-hot. `ballots_cast` increments, saturating at 255. Next state IDLE.
- `arm_rise` in any state other than IDLE is ignored.
- All outputs are registered. `voter_switch` is forced to 000 whenever `voting_en` = 0.
- A second vote needs a new `arm` rising edge. That edge must be preceded by `arm` low for at least one cycle.

## Timing
- **Reset:** when `rst` is sampled high:
  - FSM → IDLE;
  - all outputs 0, `ballots_cast` = 0;
  - synchronisers, `btn_db`, all counters and `arm_q` = 0.
- Reset mid-operation (including during SETTLE or CAST) aborts with no vote and no pulse.
- **Arm:** `arm` first sampled high at edge a → ARMED_CLR and `ready_led` = 1 after edge a+1. This assumes `arm_q` = 0.
- **Button latency:** requires arrival in ARMED, stable input, and D = `DEBOUNCE_CYCLES`. Let k be the first edge sampling `btn_raw` high.
  - `btn_db` rises after edge k+1+D.
  - SETTLE is entered at edge k+2+D.
  - `voting_en` is high for exactly the one cycle after edge k+2+2D.
  - `ready_led` falls at the same edge.
- **Bounce:** any disagreement within the D-cycle count restarts the count. Glitches shorter than D cycles never reach the FSM.
- **Staggered presses:** a second button debounced before the settle sample counts as a multi-press and gives `reject`.
- **Counter saturation:** at `ballots_cast` = 255, CAST still strobes `voting_en` and the count holds at 255.

## Configuration
- `BALLOT_TIMEOUT_EN` defined:
  - A counter runs in ARMED_CLR and ARMED. It clears on entering ARMED_CLR and is not reset by the ARMED_CLR→ARMED transition.
  - On reaching `TIMEOUT_CYCLES`: pulse `timeout` for one cycle and go to IDLE.
  - SETTLE is not subject to timeout.
- `BALLOT_TIMEOUT_EN` undefined: no timeout counter, `timeout` tied to 0, port retained.

## Test plan
- Reset, then arm, then press party2 cleanly, with D=4 → one cycle with `voting_en`=1 and `voter_switch`=010 at edge k+10; `ballots_cast`=1; `ready_led`=0 afterwards.
- Party1 bouncing at 1–3-cycle intervals for 20 cycles, then stable, with D=4 → exactly one 001 strobe; no strobe during the bounce.
- Party1 and party3 pressed together while armed → `reject` pulse, no `voting_en`, `ready_led` stays 1. After release, press party3 → strobe 100.
- Button held while `arm` rises → no vote until release. Press again → a single vote. Pressing again without a new arm → nothing.
- 256 arm/vote cycles → `ballots_cast` saturates at 255 and the 256th vote still strobes. Asserting `rst` during SETTLE → no strobe, all outputs 0.
- With `BALLOT_TIMEOUT_EN` and `TIMEOUT_CYCLES`=50: arm with no press → `timeout` pulse 50 cycles after entering ARMED_CLR, then IDLE. A later press gives no vote.
